// File: rtl/register_arbiter_if.sv
// ============================================================================
// register_arbiter_if : requester/register bundle for register_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface register_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_lock_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]         q_o;
    logic                     grant_valid_o;
    logic [IDX_W-1:0]         grant_idx_o;
    logic                     locked_o;

    modport master (
        output req_valid_i, req_lock_i, req_data_i,
        input  req_ready_o, q_o, grant_valid_o, grant_idx_o, locked_o
    );

    modport slave (
        input  req_valid_i, req_lock_i, req_data_i,
        output req_ready_o, q_o, grant_valid_o, grant_idx_o, locked_o
    );
endinterface

`default_nettype wire

// File: rtl/register_arbiter.sv
// ============================================================================
// register_arbiter : round-robin, lockable writer arbitration for one register
// Revision: 1.0
// ============================================================================
`default_nettype none

module register_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0] ready;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic               xfer;
    logic [IDX_W-1:0]   xfer_idx;
    int                 cand;
    logic [WIDTH-1:0]   slice [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign slice[g] = bus.req_data_i[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Rotating search starting at ptr; explicit wrap keeps non-power-of-2 counts correct.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && bus.req_valid_i[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ready         = '0;
        xfer          = 1'b0;
        xfer_idx      = win_idx;
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ready[win_idx] = 1'b1;
                    xfer           = 1'b1;
                    xfer_idx       = win_idx;
                    if (bus.req_lock_i[win_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = win_idx;
                    end
                end
            end
            ST_LOCKED: begin
                ready[owner_q] = bus.req_valid_i[owner_q];
                xfer_idx       = owner_q;
                if (bus.req_valid_i[owner_q]) begin
                    xfer = 1'b1;
                end
                // Dropping lock ends the sequence whether or not a final write happens.
                if (!bus.req_lock_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            if (int'(xfer_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = xfer_idx + 1'b1;
            end
        end
        grant_valid_d = xfer;
        grant_idx_d   = xfer ? xfer_idx : grant_idx_q;
        data_d        = xfer ? slice[xfer_idx] : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            data_q        <= data_d;
        end
    end

    assign bus.req_ready_o   = rst_n ? ready : '0;
    assign bus.q_o           = data_q;
    assign bus.grant_valid_o = grant_valid_q;
    assign bus.grant_idx_o   = grant_idx_q;
    assign bus.locked_o      = (state_q == ST_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_register_arbiter.sv
// ============================================================================
// tb_register_arbiter : directed and randomized checks of register_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_register_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
    register_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept at the level of the arbitration rules.
    int         m_ptr, m_owner, m_gi;
    bit         m_locked, m_gv;
    logic [W-1:0] m_q;

    logic [N-1:0]   cur_v, cur_l;
    logic [N*W-1:0] cur_d;

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        if (m_locked) begin
            r[m_owner] = v[m_owner];
        end else begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (v[c]) begin
                    r[c] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_gi = 0; m_locked = 0; m_gv = 0; m_q = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        int k;
        k = -1;
        for (int i = 0; i < N; i++) if (r[i]) k = i;
        if (k >= 0) begin
            m_q   = cur_d[k*W +: W];
            m_gv  = 1;
            m_gi  = k;
            m_ptr = (k + 1) % N;
            if (!m_locked && cur_l[k]) begin
                m_locked = 1;
                m_owner  = k;
            end else if (m_locked && !cur_l[k]) begin
                m_locked = 0;
            end
        end else begin
            m_gv = 0;
            if (m_locked && !cur_v[m_owner] && !cur_l[m_owner]) m_locked = 0;
        end
    endtask

    // Called just after a rising edge; leaves time just before the falling edge.
    task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d);
        cur_v = v; cur_l = l; cur_d = d;
        bus.req_valid_i = v;
        bus.req_lock_i  = l;
        bus.req_data_i  = d;
        #3;
    endtask

    task automatic tick();
        logic [N-1:0] r;
        r = model_ready(cur_v);
        @(posedge clk);
        #1;
        model_edge(r);
    endtask

    task automatic do_reset();
        cur_v = '0; cur_l = '0; cur_d = '0;
        bus.req_valid_i = '0;
        bus.req_lock_i  = '0;
        bus.req_data_i  = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [N*W-1:0] dA;

    task automatic test_reset();
        do_reset();
        apply(4'b1111, 4'b0000, dA); tick();
        apply(4'b1111, 4'b0000, dA); tick();
        n_checks++;
        if (bus.q_o !== 32'hA1) begin n_fail++; $display("FAIL reset_pre_q: got %h expected %h", bus.q_o, 32'hA1); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.q_o !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", bus.q_o); end
        n_checks++;
        if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o); end
        n_checks++;
        if (bus.locked_o !== 1'b0 || bus.grant_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: locked %b gv %b expected 0 0", bus.locked_o, bus.grant_valid_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 0001", bus.req_ready_o); end
        tick();
        n_checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_idx_o !== 2'd0 || bus.q_o !== 32'hA0) begin
            n_fail++; $display("FAIL reset_first_grant: gv %b idx %0d q %h expected 1 0 a0", bus.grant_valid_o, bus.grant_idx_o, bus.q_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            int k;
            k = c % N;
            apply(4'b1111, 4'b0000, dA);
            n_checks++;
            if (bus.req_ready_o !== 4'(1 << k)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, bus.req_ready_o, 4'(1 << k)); end
            tick();
            n_checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_idx_o !== 2'(k) || bus.q_o !== 32'hA0 + 32'(k)) begin
                n_fail++; $display("FAIL rr_grant[%0d]: gv %b idx %0d q %h expected 1 %0d %h", c, bus.grant_valid_o, bus.grant_idx_o, bus.q_o, k, 32'hA0 + 32'(k));
            end
        end
    endtask

    task automatic test_wrap_skip();
        int seq [3] = '{3, 1, 3};
        do_reset();
        apply(4'b0100, 4'b0000, dA); tick();
        for (int c = 0; c < 3; c++) begin
            apply(4'b1010, 4'b0000, dA);
            n_checks++;
            if (bus.req_ready_o !== 4'(1 << seq[c])) begin n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected %b", c, bus.req_ready_o, 4'(1 << seq[c])); end
            tick();
            n_checks++;
            if (bus.grant_idx_o !== 2'(seq[c]) || bus.q_o !== 32'hA0 + 32'(seq[c])) begin
                n_fail++; $display("FAIL wrap_grant[%0d]: idx %0d q %h expected %0d", c, bus.grant_idx_o, bus.q_o, seq[c]);
            end
        end
        apply(4'b1111, 4'b0000, dA);
        n_checks++;
        if (bus.req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr0: got %b expected 0001", bus.req_ready_o); end
        tick();
    endtask

    task automatic test_lock();
        logic [W-1:0] lv [3] = '{32'h11, 32'h22, 32'h33};
        logic [N-1:0] lk [3] = '{4'b0100, 4'b0100, 4'b0000};
        bit           ex [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        apply(4'b0010, 4'b0000, dA); tick();
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, lk[c], pack4(32'hA0, 32'hA1, lv[c], 32'hA3));
            n_checks++;
            if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL lock_ready[%0d]: got %b expected 0100", c, bus.req_ready_o); end
            tick();
            n_checks++;
            if (bus.q_o !== lv[c] || bus.grant_idx_o !== 2'd2 || bus.locked_o !== ex[c]) begin
                n_fail++; $display("FAIL lock_xfer[%0d]: q %h idx %0d locked %b expected %h 2 %b", c, bus.q_o, bus.grant_idx_o, bus.locked_o, lv[c], ex[c]);
            end
        end
        apply(4'b1111, 4'b0000, dA);
        n_checks++;
        if (bus.req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL lock_next: got %b expected 1000", bus.req_ready_o); end
        tick();
    endtask

    task automatic test_release();
        do_reset();
        apply(4'b0010, 4'b0010, pack4(32'h0, 32'h77, 32'h0, 32'h0)); tick();
        n_checks++;
        if (bus.locked_o !== 1'b1 || bus.q_o !== 32'h77) begin n_fail++; $display("FAIL rel_lock: locked %b q %h expected 1 77", bus.locked_o, bus.q_o); end
        apply(4'b0000, 4'b0000, dA);
        n_checks++;
        if (bus.req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rel_ready: got %b expected 0000", bus.req_ready_o); end
        tick();
        n_checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.locked_o !== 1'b0 || bus.q_o !== 32'h77) begin
            n_fail++; $display("FAIL rel_state: gv %b locked %b q %h expected 0 0 77", bus.grant_valid_o, bus.locked_o, bus.q_o);
        end
        apply(4'b1111, 4'b0000, dA);
        n_checks++;
        if (bus.req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL rel_ptr: got %b expected 0100", bus.req_ready_o); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        apply(4'b0001, 4'b0001, pack4(32'h5A, 32'h0, 32'h0, 32'h0)); tick();
        apply(4'b0000, 4'b0001, dA); tick();
        n_checks++;
        if (bus.locked_o !== 1'b1 || bus.q_o !== 32'h5A) begin n_fail++; $display("FAIL rml_hold: locked %b q %h expected 1 5a", bus.locked_o, bus.q_o); end
        apply(4'b0010, 4'b0000, pack4(32'h0, 32'h66, 32'h0, 32'h0));
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.q_o !== 32'h0 || bus.locked_o !== 1'b0) begin n_fail++; $display("FAIL rml_reset: q %h locked %b expected 0 0", bus.q_o, bus.locked_o); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready_o !== 4'b0010) begin n_fail++; $display("FAIL rml_ready: got %b expected 0010", bus.req_ready_o); end
        tick();
        n_checks++;
        if (bus.q_o !== 32'h66 || bus.grant_idx_o !== 2'd1) begin n_fail++; $display("FAIL rml_grant: q %h idx %0d expected 66 1", bus.q_o, bus.grant_idx_o); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0]   v, l;
            logic [N*W-1:0] d;
            logic [N-1:0]   er;
            v = 4'($urandom);
            l = 4'($urandom);
            for (int k = 0; k < N; k++) d[k*W +: W] = $urandom;
            apply(v, l, d);
            er = model_ready(v);
            n_checks++;
            if (bus.req_ready_o !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, bus.req_ready_o, er); end
            tick();
            n_checks++;
            if (bus.q_o !== m_q || bus.grant_valid_o !== m_gv || bus.grant_idx_o !== 2'(m_gi) || bus.locked_o !== m_locked) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: q %h gv %b idx %0d lk %b expected %h %b %0d %b",
                         c, bus.q_o, bus.grant_valid_o, bus.grant_idx_o, bus.locked_o, m_q, m_gv, m_gi, m_locked);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dA = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_lock();
        test_release();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_arbiter.md
# register_arbiter

Round-robin write arbiter that shares one WIDTH-bit holding register between NUM_REQ requesters. Each requester presents data on a valid/ready handshake, and the arbiter loads at most one winner per cycle into the register. A requester may also lock the register for a multi-transfer sequence, during which no other requester can write. The block sits between several configuration or control sources and a single shared control register consumed downstream via q_o.

## Interface
- WIDTH, 32, data width of the shared register (≥1)
- NUM_REQ, 4, number of requesters (≥1, need not be a power of 2)
- IDX_W, derived, max(1, $clog2(NUM_REQ)); localparam, not overridable

- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low; deassertion synchronised externally
- req_valid_i  input  NUM_REQ  per-requester write request
- req_lock_i  input  NUM_REQ  per-requester lock request; sampled only when relevant (see Operation)
- req_data_i  input  NUM_REQ*WIDTH  write data; requester k uses bits [k*WIDTH +: WIDTH]
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high
- q_o  output  WIDTH  current register contents
- grant_valid_o  output  1  registered strobe: q_o was written at the previous edge
- grant_idx_o  output  IDX_W  index of the requester that performed that write
- locked_o  output  1  registered; high while the FSM is in LOCKED

## Operation
- Transfer on requester k: req_valid_i[k] & req_ready_o[k] at a rising edge. The edge loads req_data_i slice k into the register.
- Round-robin pointer ptr (IDX_W bits) sets search order:
  - search ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1
  - the first valid requester is the winner
- After any transfer by k, ptr <= (k+1) mod NUM_REQ. Wrap is correct for non-power-of-2 NUM_REQ.
- ptr is unchanged on cycles with no transfer.
- FSM states: IDLE, LOCKED (with registered owner index).
- IDLE:
  - req_ready_o is one-hot on the winner, all-zero if no valid.
  - If the winner k transfers with req_lock_i[k]=1: go to LOCKED, owner <= k.
  - Otherwise stay in IDLE.
- LOCKED:
  - req_ready_o[owner] = req_valid_i[owner]; every other bit is 0, regardless of their valid.
  - Owner transfer with req_lock_i[owner]=1: write, stay LOCKED.
  - Owner transfer with req_lock_i[owner]=0: write (final transfer), go to IDLE.
  - Owner req_valid_i=0 and req_lock_i=0: release without a write, go to IDLE. ptr is unchanged.
  - Owner req_valid_i=0 and req_lock_i=1: hold LOCKED, no write.
- Lock from a requester that is not currently winning in IDLE is ignored.
- No transfer means the register holds its value.
- NUM_REQ=1: ptr stays 0, requester 0 always wins when valid, and lock behaves as specified.
- Reset (rst_n=0, any time, including mid-lock), asynchronously:
  - q_o=0, ptr=0, FSM=IDLE, owner=0
  - grant_valid_o=0, grant_idx_o=0, locked_o=0
  - req_ready_o=0 while reset is asserted

## Timing
- req_ready_o is combinational from req_valid_i, req_lock_i, ptr, FSM state and owner. It never depends on req_data_i.
- Requesters must not make req_valid_i depend on req_ready_o, which would form a combinational loop.
- Write latency: data accepted at edge N appears on q_o immediately after edge N.
- At that same edge N:
  - grant_valid_o=1 and grant_idx_o=k for one cycle (high until edge N+1)
  - locked_o reflects the new FSM state
- Back-to-back transfers are allowed every cycle; throughput is one write per cycle.
- Lock exit in cycle N lets any requester win in cycle N+1. It is never re-granted to the old owner in cycle N.
- grant_idx_o holds its last value when grant_valid_o=0.

## Test plan
- Reset value:
  - Assert rst_n=0 asynchronously mid-cycle with all valids high.
  - Required: q_o=0, req_ready_o=0, locked_o=0, grant_valid_o=0 immediately. After release, requester 0 wins first.
- Round robin, NUM_REQ=4, WIDTH=32:
  - Drive all valids continuously with data 0xA0+k.
  - Required: grants go 0,1,2,3,0; q_o sequences 0xA0,0xA1,0xA2,0xA3,0xA0; grant_idx_o tracks each write one edge later.
- Wrap and skip:
  - ptr=3 with only requesters 1 and 3 valid.
  - Required: 3 wins, then 1, then 3; ptr values 0, 2, 0.
- Lock sequence:
  - Requester 2 does three transfers (lock 1,1,0) with data 0x11,0x22,0x33 while requesters 0, 1 and 3 stay valid.
  - Required: only req_ready_o[2] asserts; locked_o is high for two cycles; q_o ends at 0x33; requester 3 wins next.
- Release without write:
  - Owner 1 drops valid and lock together.
  - Required: no write, grant_valid_o=0, IDLE next cycle, ptr unchanged at 2.
- Reset mid-lock:
  - Owner 0 holds lock, q_o=0x5A; pulse rst_n low.
  - Required: q_o=0, locked_o=0, requester 1 can win on the first cycle after release.
